// File: rtl/rs_multi_station.sv
// rs_multi_station: multi-entry reservation station for one functional-unit
// class. It allocates the lowest free entry on issue, snoops the CDB for
// outstanding source tags (including on the issue cycle itself), selects one
// operand-complete entry per cycle for dispatch and frees it on handshake.
//
// Optional feature macro: RS_AGE_PRIORITY_EN
//   defined   -> the oldest ready entry is dispatched (age matrix)
//   undefined -> the lowest-index ready entry is dispatched (no age state)
//
// Ports:
//   clk, rst (sync, active low)  clock / reset
//   flush                        discard every entry
//   issue_valid/ready/op/q1/q2/v1/v2, issue_tag   issue side
//   cdb_valid/tag/data           common data bus snoop
//   disp_valid/ready/op/v1/v2/tag  dispatch side towards the FU
//   occupancy                    number of busy entries
module rs_multi_station #(
  parameter int DEPTH    = 4,
  parameter int TAG_W    = 8,
  parameter int DATA_W   = 32,
  parameter int OP_W     = 5,
  parameter int BASE_TAG = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [OP_W-1:0]              issue_op,
  input  logic [TAG_W-1:0]             issue_q1,
  input  logic [TAG_W-1:0]             issue_q2,
  input  logic [DATA_W-1:0]            issue_v1,
  input  logic [DATA_W-1:0]            issue_v2,
  output logic [TAG_W-1:0]             issue_tag,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [DATA_W-1:0]            cdb_data,
  output logic                         disp_valid,
  input  logic                         disp_ready,
  output logic [OP_W-1:0]              disp_op,
  output logic [DATA_W-1:0]            disp_v1,
  output logic [DATA_W-1:0]            disp_v2,
  output logic [TAG_W-1:0]             disp_tag,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [TAG_W-1:0] BASE = TAG_W'(BASE_TAG);

  logic [DEPTH-1:0]  busy_vec;
  logic [DEPTH-1:0]  ready_vec;
  logic [DEPTH-1:0]  eligible_vec;
  logic [DEPTH-1:0]  alloc_vec;
  logic [DEPTH-1:0]  free_vec;
  logic [OP_W-1:0]   op_arr [DEPTH];
  logic [DATA_W-1:0] v1_arr [DEPTH];
  logic [DATA_W-1:0] v2_arr [DEPTH];

  logic [IDX_W-1:0]  free_idx;
  logic              free_found;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_found;
  logic              alloc_fire;
  logic              disp_fire;
  logic              cap1;
  logic              cap2;
  logic [OCC_W-1:0]  occupancy_reg;

  // Lowest-index free entry, from registered busy bits only.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!busy_vec[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign issue_ready = free_found;
  assign issue_tag   = BASE + TAG_W'(free_idx);
  assign alloc_fire  = issue_valid && issue_ready && !flush;
  assign disp_fire   = disp_valid && disp_ready && !flush;
  assign alloc_vec   = alloc_fire ? (DEPTH'(1) << free_idx) : '0;
  assign free_vec    = disp_fire ? (DEPTH'(1) << sel_idx) : '0;

  // Same-cycle capture of a source operand broadcast while it is being issued.
  assign cap1 = cdb_valid && (issue_q1 != '0) && (cdb_tag == issue_q1);
  assign cap2 = cdb_valid && (issue_q2 != '0) && (cdb_tag == issue_q2);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
    logic              busy_reg;
    logic [OP_W-1:0]   op_reg;
    logic [TAG_W-1:0]  q1_reg;
    logic [TAG_W-1:0]  q2_reg;
    logic [DATA_W-1:0] v1_reg;
    logic [DATA_W-1:0] v2_reg;
    logic              wake1;
    logic              wake2;

    // q==0 never matches, so a tag-0 broadcast cannot disturb ready operands.
    assign wake1 = cdb_valid && (q1_reg != '0) && (cdb_tag == q1_reg);
    assign wake2 = cdb_valid && (q2_reg != '0) && (cdb_tag == q2_reg);

    always_ff @(posedge clk) begin
      if (!rst) begin
        busy_reg <= 1'b0;
        op_reg   <= '0;
        q1_reg   <= '0;
        q2_reg   <= '0;
        v1_reg   <= '0;
        v2_reg   <= '0;
      end else if (flush) begin
        busy_reg <= 1'b0;
      end else if (alloc_vec[gi]) begin
        busy_reg <= 1'b1;
        op_reg   <= issue_op;
        q1_reg   <= cap1 ? '0 : issue_q1;
        v1_reg   <= cap1 ? cdb_data : issue_v1;
        q2_reg   <= cap2 ? '0 : issue_q2;
        v2_reg   <= cap2 ? cdb_data : issue_v2;
      end else begin
        if (free_vec[gi]) begin
          busy_reg <= 1'b0;
        end
        if (busy_reg && wake1) begin
          q1_reg <= '0;
          v1_reg <= cdb_data;
        end
        if (busy_reg && wake2) begin
          q2_reg <= '0;
          v2_reg <= cdb_data;
        end
      end
    end

    assign busy_vec[gi]  = busy_reg;
    assign ready_vec[gi] = busy_reg && (q1_reg == '0) && (q2_reg == '0);
    assign op_arr[gi]    = op_reg;
    assign v1_arr[gi]    = v1_reg;
    assign v2_arr[gi]    = v2_reg;
  end

`ifdef RS_AGE_PRIORITY_EN
  // older_arr[i][j] set means entry i was issued before entry j.
  logic [DEPTH-1:0] older_arr [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_age
    logic [DEPTH-1:0] row_reg;

    always_ff @(posedge clk) begin
      if (!rst || flush) begin
        row_reg <= '0;
      end else if (alloc_vec[gi] || free_vec[gi]) begin
        // A new entry is younger than everything; a freed one is older than nothing.
        row_reg <= '0;
      end else begin
        row_reg <= (row_reg & ~free_vec) | (busy_vec[gi] ? alloc_vec : '0);
      end
    end

    assign older_arr[gi] = row_reg;
  end

  // A ready entry is eligible only if no other ready entry is older.
  always_comb begin
    eligible_vec = ready_vec;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (ready_vec[j] && older_arr[j][i]) begin
          eligible_vec[i] = 1'b0;
        end
      end
    end
  end
`else
  assign eligible_vec = ready_vec;
`endif

  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (eligible_vec[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign disp_valid = sel_found;
  assign disp_op    = disp_valid ? op_arr[sel_idx] : '0;
  assign disp_v1    = disp_valid ? v1_arr[sel_idx] : '0;
  assign disp_v2    = disp_valid ? v2_arr[sel_idx] : '0;
  assign disp_tag   = BASE + TAG_W'(sel_idx);

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      occupancy_reg <= '0;
    end else if (alloc_fire && !disp_fire) begin
      occupancy_reg <= occupancy_reg + OCC_W'(1);
    end else if (disp_fire && !alloc_fire) begin
      occupancy_reg <= occupancy_reg - OCC_W'(1);
    end
  end

  assign occupancy = occupancy_reg;

endmodule

// File: tb/tb_rs_multi_station.sv
module tb_rs_multi_station;
  localparam int DEPTH  = 4;
  localparam int TAG_W  = 8;
  localparam int DATA_W = 32;
  localparam int OP_W   = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              issue_valid = 1'b0;
  logic              issue_ready;
  logic [OP_W-1:0]   issue_op = '0;
  logic [TAG_W-1:0]  issue_q1 = '0;
  logic [TAG_W-1:0]  issue_q2 = '0;
  logic [DATA_W-1:0] issue_v1 = '0;
  logic [DATA_W-1:0] issue_v2 = '0;
  logic [TAG_W-1:0]  issue_tag;
  logic              cdb_valid = 1'b0;
  logic [TAG_W-1:0]  cdb_tag = '0;
  logic [DATA_W-1:0] cdb_data = '0;
  logic              disp_valid;
  logic              disp_ready = 1'b0;
  logic [OP_W-1:0]   disp_op;
  logic [DATA_W-1:0] disp_v1;
  logic [DATA_W-1:0] disp_v2;
  logic [TAG_W-1:0]  disp_tag;
  logic [2:0]        occupancy;

  rs_multi_station #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W), .BASE_TAG(1)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_q1(issue_q1), .issue_q2(issue_q2), .issue_v1(issue_v1), .issue_v2(issue_v2),
    .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_v1(disp_v1), .disp_v2(disp_v2), .disp_tag(disp_tag),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Reference model: a set of slots plus an issue sequence number for age.
  bit                m_busy [DEPTH];
  logic [OP_W-1:0]   m_op   [DEPTH];
  logic [TAG_W-1:0]  m_q1   [DEPTH];
  logic [TAG_W-1:0]  m_q2   [DEPTH];
  logic [DATA_W-1:0] m_v1   [DEPTH];
  logic [DATA_W-1:0] m_v2   [DEPTH];
  int unsigned       m_seq  [DEPTH];
  int unsigned       seq_ctr = 0;
  int                e_free;
  int                e_sel;
  int                e_occ;
  int                disp_log [$];
  int                checks = 0;
  int                failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_eval();
    e_free = -1;
    e_sel  = -1;
    e_occ  = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_busy[i]) e_occ++;
      if (!m_busy[i] && e_free < 0) e_free = i;
      if (m_busy[i] && m_q1[i] == 0 && m_q2[i] == 0) begin
`ifdef RS_AGE_PRIORITY_EN
        if (e_sel < 0 || m_seq[i] < m_seq[e_sel]) e_sel = i;
`else
        if (e_sel < 0) e_sel = i;
`endif
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_busy[i] = 0; m_op[i] = '0; m_q1[i] = '0; m_q2[i] = '0;
      m_v1[i] = '0; m_v2[i] = '0; m_seq[i] = 0;
    end
    seq_ctr = 0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    bit fire_a;
    bit fire_d;
    @(negedge clk);
    if (rst) begin
      model_eval();
      check("issue_ready", issue_ready, e_free >= 0);
      if (e_free >= 0) check("issue_tag", issue_tag, 1 + e_free);
      check("occupancy", occupancy, e_occ);
      check("disp_valid", disp_valid, e_sel >= 0);
      if (e_sel >= 0) begin
        check("disp_tag", disp_tag, 1 + e_sel);
        check("disp_op", disp_op, m_op[e_sel]);
        check("disp_v1", disp_v1, m_v1[e_sel]);
        check("disp_v2", disp_v2, m_v2[e_sel]);
      end
      if (disp_valid && disp_ready && !flush) disp_log.push_back(int'(disp_tag));
    end
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
    end else begin
      fire_a = issue_valid && (e_free >= 0);
      fire_d = (e_sel >= 0) && disp_ready;
      for (int i = 0; i < DEPTH; i++) begin
        if (m_busy[i] && cdb_valid && cdb_tag != 0) begin
          if (m_q1[i] == cdb_tag) begin m_q1[i] = '0; m_v1[i] = cdb_data; end
          if (m_q2[i] == cdb_tag) begin m_q2[i] = '0; m_v2[i] = cdb_data; end
        end
      end
      if (fire_d) m_busy[e_sel] = 0;
      if (fire_a) begin
        m_busy[e_free] = 1;
        m_op[e_free]   = issue_op;
        m_seq[e_free]  = seq_ctr++;
        if (cdb_valid && issue_q1 != 0 && cdb_tag == issue_q1) begin
          m_q1[e_free] = '0; m_v1[e_free] = cdb_data;
        end else begin
          m_q1[e_free] = issue_q1; m_v1[e_free] = issue_v1;
        end
        if (cdb_valid && issue_q2 != 0 && cdb_tag == issue_q2) begin
          m_q2[e_free] = '0; m_v2[e_free] = cdb_data;
        end else begin
          m_q2[e_free] = issue_q2; m_v2[e_free] = issue_v2;
        end
      end
    end
    #1;
  endtask

  task automatic set_idle();
    issue_valid = 0; flush = 0; cdb_valid = 0; cdb_tag = '0; cdb_data = '0;
    disp_ready = 0; issue_op = '0; issue_q1 = '0; issue_q2 = '0;
    issue_v1 = '0; issue_v2 = '0;
  endtask

  task automatic do_issue(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] q1,
                          input logic [DATA_W-1:0] v1, input logic [TAG_W-1:0] q2,
                          input logic [DATA_W-1:0] v2);
    issue_valid = 1; issue_op = op; issue_q1 = q1; issue_v1 = v1;
    issue_q2 = q2; issue_v2 = v2;
  endtask

  initial begin
    model_reset();
    set_idle();
    // Reset
    rst = 0;
    cycle();
    cycle();
    rst = 1;
    check("rst_occupancy", occupancy, 0);
    check("rst_disp_valid", disp_valid, 0);
    check("rst_issue_ready", issue_ready, 1);
    check("rst_issue_tag", issue_tag, 1);
    check("rst_disp_tag", disp_tag, 1);
    check("rst_disp_op", disp_op, 0);
    check("rst_disp_v1", disp_v1, 0);

    // Ready-at-issue instruction dispatches next cycle
    do_issue(5'd3, 8'd0, 32'd5, 8'd0, 32'd7);
    disp_ready = 1;
    cycle();
    issue_valid = 0;
    check("basic_valid", disp_valid, 1);
    check("basic_v1", disp_v1, 5);
    check("basic_v2", disp_v2, 7);
    check("basic_tag", disp_tag, 1);
    check("basic_op", disp_op, 3);
    cycle();
    check("basic_freed", occupancy, 0);
    check("basic_empty", disp_valid, 0);

    // Issue-cycle CDB capture, then a tag-0 broadcast
    set_idle();
    do_issue(5'd4, 8'd9, 32'd0, 8'd0, 32'd3);
    cdb_valid = 1; cdb_tag = 8'd9; cdb_data = 32'hAA;
    cycle();
    set_idle();
    check("capture_valid", disp_valid, 1);
    check("capture_v1", disp_v1, 32'hAA);
    cdb_valid = 1; cdb_tag = 8'd0; cdb_data = 32'hDEAD;
    cycle();
    check("tag0_v1", disp_v1, 32'hAA);
    check("tag0_v2", disp_v2, 3);
    set_idle();
    disp_ready = 1;
    cycle();
    set_idle();

    // Fill every entry waiting on tag 6, wake them all, drain in order
    for (int i = 0; i < DEPTH; i++) begin
      do_issue(OP_W'(i + 1), 8'd6, 32'd0, 8'd0, DATA_W'(i));
      cycle();
    end
    check("full_ready", issue_ready, 0);
    check("full_occ", occupancy, 4);
    do_issue(5'd31, 8'd0, 32'd1, 8'd0, 32'd1);
    cycle();
    check("full_ignored_occ", occupancy, 4);
    set_idle();
    cdb_valid = 1; cdb_tag = 8'd6; cdb_data = 32'h66;
    cycle();
    set_idle();
    check("wake_all_valid", disp_valid, 1);
    disp_log.delete();
    disp_ready = 1;
    for (int i = 0; i < DEPTH; i++) cycle();
    set_idle();
    check("drain_count", disp_log.size(), 4);
    for (int i = 0; i < DEPTH; i++) begin
      int got;
      got = (i < disp_log.size()) ? disp_log[i] : 0;
      check($sformatf("drain_tag%0d", i), got, i + 1);
    end

    // Age ordering: A waits in entry 0, B ready in entry 1, C reuses entry 0
    do_issue(5'd10, 8'd6, 32'd0, 8'd0, 32'd0);
    cycle();
    do_issue(5'd11, 8'd0, 32'd1, 8'd0, 32'd2);
    cycle();
    set_idle();
    cdb_valid = 1; cdb_tag = 8'd6; cdb_data = 32'h16;
    cycle();
    set_idle();
    disp_ready = 1;
    cycle();
    set_idle();
    do_issue(5'd12, 8'd0, 32'd3, 8'd0, 32'd4);
    cycle();
    set_idle();
    disp_log.delete();
    disp_ready = 1;
    cycle();
    cycle();
    set_idle();
    check("age_count", disp_log.size(), 2);
`ifdef RS_AGE_PRIORITY_EN
    check("age_first", (disp_log.size() > 0) ? disp_log[0] : 0, 2);
`else
    check("age_first", (disp_log.size() > 0) ? disp_log[0] : 0, 1);
`endif

    // Flush together with issue and dispatch
    do_issue(5'd13, 8'd0, 32'd9, 8'd0, 32'd9);
    cycle();
    do_issue(5'd20, 8'd0, 32'h20, 8'd0, 32'h21);
    disp_ready = 1;
    flush = 1;
    cycle();
    set_idle();
    check("flush_occ", occupancy, 0);
    check("flush_disp_valid", disp_valid, 0);
    disp_log.delete();
    disp_ready = 1;
    for (int i = 0; i < 3; i++) cycle();
    check("flush_no_dispatch", disp_log.size(), 0);
    set_idle();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 199) != 0);
      flush       = ($urandom_range(0, 39) == 0);
      issue_valid = ($urandom_range(0, 9) < 6);
      issue_op    = OP_W'($urandom);
      issue_q1    = ($urandom_range(0, 1) == 0) ? 8'd0 : TAG_W'($urandom_range(1, 9));
      issue_q2    = ($urandom_range(0, 1) == 0) ? 8'd0 : TAG_W'($urandom_range(1, 9));
      issue_v1    = $urandom;
      issue_v2    = $urandom;
      cdb_valid   = ($urandom_range(0, 1) == 1);
      cdb_tag     = TAG_W'($urandom_range(0, 9));
      cdb_data    = $urandom;
      disp_ready  = ($urandom_range(0, 1) == 1);
      cycle();
    end
    rst = 1;
    set_idle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rs_multi_station.md
# rs_multi_station

Parametrised multi-entry reservation station for the Tomasulo core. It holds up to DEPTH issued instructions and snoops the CDB for outstanding operand tags, including on the issue cycle. Each cycle it dispatches one operand-complete entry to its functional unit. It sits between the issue stage and one FU class (ALU, MUL, DIV, LSU), and replaces per-line stations with one block that allocates, wakes up, selects and frees entries.

## Interface
Parameters:
- DEPTH, 4: number of entries, 2..16.
- TAG_W, 8: tag width. Tag 0 is reserved and means "value present".
- DATA_W, 32: operand and CDB data width.
- OP_W, 5: opcode/function field width, carried through unchanged.
- BASE_TAG, 1: tag of entry 0. Entry i owns tag BASE_TAG+i. Must be nonzero and BASE_TAG+DEPTH-1 < 2^TAG_W.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- flush  in  1  discard all entries (mispredict/exception).
- issue_valid  in  1  issue request.
- issue_ready  out  1  at least one entry free.
- issue_op  in  OP_W  opcode.
- issue_q1, issue_q2  in  TAG_W  source tags (0 = ready).
- issue_v1, issue_v2  in  DATA_W  source values, used when the tag is 0.
- issue_tag  out  TAG_W  tag the entry allocated this cycle will own. Valid when issue_ready is high.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_data  in  DATA_W  broadcast value.
- disp_valid  out  1  selected entry is ready.
- disp_ready  in  1  FU accepts.
- disp_op  out  OP_W  opcode of the selected entry.
- disp_v1, disp_v2  out  DATA_W  operands of the selected entry.
- disp_tag  out  TAG_W  tag of the selected entry.
- occupancy  out  clog2(DEPTH+1)  number of busy entries.

## Operation
- Per-entry state: busy, op, q1, v1, q2, v2.
- An entry is ready when busy, q1==0 and q2==0.
- Issue:
  - Allocation fires when issue_valid && issue_ready && !flush.
  - The allocated entry is the lowest-index free entry; issue_tag = BASE_TAG + that index.
- Same-cycle capture on issue: if cdb_valid, issue_qN != 0 and cdb_tag == issue_qN, the entry stores qN=0 and vN=cdb_data. Otherwise it stores issue_qN and issue_vN.
- Wake-up: a busy entry with qN != 0 and cdb_tag == qN under cdb_valid loads vN=cdb_data and clears qN. Broadcasts with cdb_tag==0 never match anything.
- Select: disp_valid is high if any entry is ready. The disp_* outputs are combinational muxes from registered entry state.
- Dispatch: disp_valid && disp_ready frees the selected entry at the clock edge.
- disp_* outputs stay stable while disp_valid && !disp_ready, unless a strictly higher-priority entry becomes ready.
- Flush: clears every busy bit and zeroes occupancy at the edge. It overrides issue, wake-up and dispatch in the same cycle.
- Occupancy: +1 on issue, -1 on dispatch, unchanged when both happen in the same cycle.

## Timing
- Reset (rst==0 at an edge): all busy=0, q/v/op=0, age state cleared. After reset: issue_ready=1, issue_tag=BASE_TAG, disp_valid=0, disp_op/v1/v2=0, disp_tag=BASE_TAG, occupancy=0.
- Reset has priority over flush, issue and dispatch.
- Issue-to-dispatch: a ready-at-issue instruction issued in cycle N can assert disp_valid in cycle N+1 at the earliest.
- CDB wake-up in cycle N: the entry is ready in N+1. There is no CDB-to-dispatch bypass.
- issue_ready is computed from registered busy bits only. An entry freed by dispatch in cycle N is allocatable in N+1, not in N.
- Full: when all DEPTH entries are busy, issue_ready=0 and issue_valid is ignored.
- Empty: disp_valid=0 and disp_ready is ignored.
- The same tag on the CDB matching both q1 and q2 of one entry captures both operands in the same edge.
- Issue and dispatch in the same cycle are both honoured.

## Configuration
- RS_AGE_PRIORITY_EN defined:
  - Selection picks the oldest ready entry (earliest issued), tracked with a DEPTH×DEPTH age matrix updated on issue and cleared on free/flush.
  - Ties are impossible.
- RS_AGE_PRIORITY_EN undefined:
  - Selection picks the lowest-index ready entry.
  - No age state is synthesised.

## Test plan
- Reset: hold rst=0 for 2 cycles -> occupancy=0, disp_valid=0, issue_ready=1, issue_tag=1.
- Issue {q1=0,v1=5,q2=0,v2=7,op=3} with disp_ready=1 -> next cycle disp_valid=1, v1=5, v2=7, disp_tag=1; entry freed the cycle after.
- Issue with q1=9 while the CDB broadcasts tag 9, data 0xAA in the same cycle -> entry ready next cycle with disp_v1=0xAA. Separately, a tag-0 CDB broadcast leaves every entry unchanged.
- Fill all 4 entries with q1=6 (DEPTH=4), disp_ready=0 -> issue_ready=0, occupancy=4. Broadcast tag 6 -> all four ready. Then disp_ready=1 -> tags drain 1,2,3,4 in both configs.
- With RS_AGE_PRIORITY_EN: issue A(q1=6) into entry 0, then B(ready) into entry 1, then free entry 0 via broadcast/dispatch and issue C(ready) into entry 0 -> B dispatches before C. Without the macro, C dispatches first.
- Flush in the same cycle as an issue and a dispatch -> occupancy=0, disp_valid=0 next cycle, and the issued op is never dispatched.
